alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One command in flight at a time: IDLE grants, EXEC samples the ALU, RESP holds the result.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid_i,
    input  logic [88:0] req0_cmd_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [88:0] req1_cmd_i,
    output logic        req1_ready_o,
    output logic [3:0]  alu_operation_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_shamt_o,
    output logic [15:0] alu_imm_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o,
    input  logic        rsp_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_next;
    logic [88:0] cmd_q;
    logic        cmd_id_q;
    logic        prio_q;
    logic [31:0] rsp_data_q;
    logic        rsp_zero_q;
    logic        grant;
    logic        grant_id;

    // Grant is suppressed while reset is high so no requester sees a spurious accept.
    always_comb begin
        state_next = state_q;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (req0_valid_i || req1_valid_i)) begin
                    grant      = 1'b1;
                    grant_id   = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready_o = grant & ~grant_id;
    assign req1_ready_o = grant & grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            cmd_q      <= '0;
            cmd_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q <= state_next;
            if (grant) begin
                cmd_q    <= grant_id ? req1_cmd_i : req0_cmd_i;
                cmd_id_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_data_i;
                rsp_zero_q <= alu_zero_i;
            end
            // Pointer favours the requester that was not just served.
            if (state_q == RESP && rsp_ready_i) begin
                prio_q <= ~cmd_id_q;
            end
        end
    end

    assign alu_operation_o = cmd_q[88:85];
    assign alu_shamt_o     = cmd_q[84:80];
    assign alu_imm_o       = cmd_q[79:64];
    assign alu_a_o         = cmd_q[63:32];
    assign alu_b_o         = cmd_q[31:0];

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = cmd_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU answers the DUT, grants push expected
// responses, and a negedge monitor checks arbitration, latency, hold-under-backpressure and data.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0_valid, req1_valid;
    logic [88:0] req0_cmd, req1_cmd;
    logic        req0_ready, req1_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_data;
    logic [4:0]  alu_shamt;
    logic [15:0] alu_imm;
    logic        alu_zero;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_ready;
    logic [31:0] rsp_data;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid), .req0_cmd_i(req0_cmd), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_cmd_i(req1_cmd), .req1_ready_o(req1_ready),
        .alu_operation_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_shamt_o(alu_shamt), .alu_imm_o(alu_imm),
        .alu_data_i(alu_data), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .rsp_zero_o(rsp_zero), .rsp_ready_i(rsp_ready)
    );

    // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL a, 6 SRL a, 7 LUI, others yield 0.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic [15:0] imm);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return {imm, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_data = alu_fn(alu_op, alu_a, alu_b, alu_shamt, alu_imm);
        alu_zero = (alu_data == 32'h0);
    end

    function automatic logic [88:0] mk(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] sh,
                                       input logic [15:0] imm);
        return {op, sh, imm, a, b};
    endfunction

    function automatic logic [88:0] rand_cmd();
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        return mk(4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)), 16'($urandom));
    endfunction

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0, n_vec = 0, n_err = 0, last_grant = -100, tmo = 0;
    logic        pref = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_id = 1'b0, prev_zero = 1'b0;
    logic [31:0] prev_data = '0;
    logic        chk_zero = 1'b0, finish_req = 1'b0;
    logic        g0, g1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [88:0] c;
        cyc++;
        if (chk_zero) begin
            chk("rst_req0_ready", 32'(req0_ready), 0);
            chk("rst_req1_ready", 32'(req1_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_zero", 32'(rsp_zero), 0);
            chk("rst_alu_op", 32'(alu_op), 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_shamt", 32'(alu_shamt), 0);
            chk("rst_alu_imm", 32'(alu_imm), 0);
        end
        if (reset) begin
            sb.delete();
            pref       = 1'b0;
            prev_valid = 1'b0;
            last_grant = -100;
        end else begin
            if (req0_ready || req1_ready) begin
                chk("single_ready", 32'(req0_ready & req1_ready), 0);
                chk("ready_without_valid", 32'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 0);
                chk("ready_while_busy", 32'(rsp_valid), 0);
                chk("grant_id", 32'(req1_ready),
                    32'((req0_valid && req1_valid) ? pref : req1_valid));
                chk("issue_interval", 32'(cyc - last_grant >= 3), 1);
                last_grant = cyc;
                c      = req1_ready ? req1_cmd : req0_cmd;
                e.id   = req1_ready;
                e.data = alu_fn(c[88:85], c[63:32], c[31:0], c[84:80], c[79:64]);
                e.zero = (e.data == 32'h0);
                e.cyc  = cyc;
                sb.push_back(e);
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                else                chk("latency", 32'(cyc - sb[0].cyc), 2);
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_id", 32'(rsp_id), 32'(prev_id));
                chk("hold_data", rsp_data, prev_data);
                chk("hold_zero", 32'(rsp_zero), 32'(prev_zero));
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                pref = ~e.id;
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_id    = rsp_id;
            prev_data  = rsp_data;
            prev_zero  = rsp_zero;
        end
        if (finish_req) begin
            chk("drain_empty", 32'(sb.size()), 0);
            chk("timeouts", 32'(tmo), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic step();
        @(negedge clk);
        g0 = req0_ready;
        g1 = req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic id);
        int i;
        for (i = 0; i < 40; i++) begin
            step();
            if ((id == 1'b0 && g0) || (id == 1'b1 && g1)) break;
        end
        if (i == 40) tmo++;
    endtask

    task automatic run(input int n, input bit starve, input bit rnd_rdy);
        for (int i = 0; i < n; i++) begin
            step();
            if (g0) begin
                req0_valid = starve ? 1'b1 : ($urandom_range(0, 1) == 1);
                req0_cmd   = rand_cmd();
            end else if (!req0_valid && !starve) begin
                req0_valid = ($urandom_range(0, 2) == 0);
                req0_cmd   = rand_cmd();
            end
            if (g1) begin
                req1_valid = starve ? 1'b1 : ($urandom_range(0, 1) == 1);
                req1_cmd   = rand_cmd();
            end else if (!req1_valid && !starve) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_cmd   = rand_cmd();
            end
            rsp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        chk_zero   = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_cmd   = mk(4'd1, 32'd9, 32'd9, 5'd0, 16'h0);
        req1_valid = 1'b1;
        req1_cmd   = mk(4'd3, 32'h000000F0, 32'h0000000F, 5'd0, 16'h0);
        repeat (2) step();
        chk_zero = 1'b0;
        reset    = 1'b0;

        // Contention from reset: req0, req1, then req0 again while both stay valid.
        k = 0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            step();
            if (g0 || g1) k++;
        end
        if (k < 3) tmo++;
        if (g0) req0_valid = 1'b0;
        else    req1_valid = 1'b0;
        if (req1_valid) begin
            wait_grant(1'b1);
            req1_valid = 1'b0;
        end
        if (req0_valid) begin
            wait_grant(1'b0);
            req0_valid = 1'b0;
        end
        repeat (3) step();

        // Single request: ADD 5 + 7.
        req0_cmd   = mk(4'd0, 32'd5, 32'd7, 5'd0, 16'h0);
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        repeat (3) step();

        // Backpressure: response held for several cycles while req1 waits.
        rsp_ready  = 1'b0;
        req0_cmd   = rand_cmd();
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        req1_cmd   = rand_cmd();
        req1_valid = 1'b1;
        repeat (7) step();
        rsp_ready = 1'b1;
        wait_grant(1'b1);
        req1_valid = 1'b0;
        repeat (3) step();

        // Reset while the LUI from req1 is executing: no response may follow.
        req1_cmd   = mk(4'd7, 32'h0, 32'h0, 5'd0, 16'h1234);
        req1_valid = 1'b1;
        wait_grant(1'b1);
        req1_valid = 1'b0;
        reset      = 1'b1;
        step();
        chk_zero = 1'b1;
        reset    = 1'b0;
        step();
        chk_zero = 1'b0;
        repeat (4) step();

        // Both requesters continuously valid: strict alternation.
        req0_cmd   = rand_cmd();
        req1_cmd   = rand_cmd();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        run(32, 1'b1, 1'b0);

        run(400, 1'b0, 1'b1);

        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && (req0_valid || req1_valid); i++) begin
            step();
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) tmo++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) step();
        finish_req = 1'b1;
        step();
        step();
        $display("FAIL finish: monitor did not end the run");
        $fatal(1);
    end

endmodule
